// File: rtl/jvs_clk_div_group.sv
// Divided-clock group: CH_NUM independent programmable dividers, each with a
// one-entry valid/ready config shadow and a sequenced per-channel reset.

module jvs_clk_div_ch #(
    parameter int DIV_W   = 8,
    parameter int RST_CYC = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             en_i,
    output logic             pending_o,
    output logic             div_clk_o,
    output logic             clk_en_o,
    output logic             ch_reset_n_o,
    output logic             ch_run_o
);
    localparam logic [1:0] S_OFF  = 2'd0;
    localparam logic [1:0] S_RST  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;
    localparam logic [7:0] RST_LAST = 8'(RST_CYC);

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d, d_q, d_d, sh_div_q, sh_div_d;
    logic [7:0]       rcnt_q, rcnt_d;
    logic             sh_en_q, sh_en_d, pend_q, pend_d;
    logic             div_clk_q, div_clk_d, clk_en_q, clk_en_d, run_q, run_d;
    logic             wrap, rise, fall;

    assign wrap = (cnt_q == d_q);
    assign rise = wrap && !div_clk_q;
    assign fall = wrap && div_clk_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        d_d       = d_q;
        rcnt_d    = rcnt_q;
        sh_div_d  = sh_div_q;
        sh_en_d   = sh_en_q;
        pend_d    = pend_q;
        div_clk_d = div_clk_q;
        clk_en_d  = 1'b0;
        run_d     = run_q;
        case (state_q)
            S_OFF: begin
                cnt_d     = '0;
                div_clk_d = 1'b0;
                run_d     = 1'b0;
                if (pend_q) begin
                    pend_d = 1'b0;
                    if (sh_en_q) begin
                        d_d     = sh_div_q;
                        rcnt_d  = '0;
                        state_d = S_RST;
                    end
                end
            end
            S_RST, S_RUN: begin
                if (pend_q && !sh_en_q) begin
                    // No new rise once disabled, so the clock is low within d+1 cycles.
                    pend_d  = 1'b0;
                    run_d   = 1'b0;
                    state_d = S_STOP;
                    if (div_clk_q) begin
                        cnt_d     = wrap ? '0 : cnt_q + DIV_W'(1);
                        div_clk_d = !wrap;
                    end
                end else begin
                    cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
                    if (wrap) div_clk_d = !div_clk_q;
                    if (rise) begin
                        clk_en_d = 1'b1;
                        if (state_q == S_RST) rcnt_d = rcnt_q + 8'd1;
                        // New divider takes over at a rising edge: whole phases only.
                        if (pend_q) begin
                            d_d    = sh_div_q;
                            pend_d = 1'b0;
                        end
                    end
                    if (state_q == S_RST && fall && rcnt_q >= RST_LAST) begin
                        state_d = S_RUN;
                        run_d   = 1'b1;
                    end
                end
            end
            default: begin
                if (pend_q && !sh_en_q) pend_d = 1'b0;
                if (div_clk_q && !wrap) begin
                    cnt_d = cnt_q + DIV_W'(1);
                end else begin
                    cnt_d     = '0;
                    div_clk_d = 1'b0;
                    state_d   = S_OFF;
                end
            end
        endcase
        if (wr_i) begin
            sh_div_d = div_i;
            sh_en_d  = en_i;
            pend_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_OFF;
            cnt_q     <= '0;
            d_q       <= '0;
            rcnt_q    <= '0;
            sh_div_q  <= '0;
            sh_en_q   <= 1'b0;
            pend_q    <= 1'b0;
            div_clk_q <= 1'b0;
            clk_en_q  <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            d_q       <= d_d;
            rcnt_q    <= rcnt_d;
            sh_div_q  <= sh_div_d;
            sh_en_q   <= sh_en_d;
            pend_q    <= pend_d;
            div_clk_q <= div_clk_d;
            clk_en_q  <= clk_en_d;
            run_q     <= run_d;
        end
    end

    assign pending_o    = pend_q;
    assign div_clk_o    = div_clk_q;
    assign clk_en_o     = clk_en_q;
    assign ch_reset_n_o = run_q;
    assign ch_run_o     = run_q;
endmodule

module jvs_clk_div_group #(
    parameter int  CH_NUM  = 4,
    parameter int  DIV_W   = 8,
    parameter int  RST_CYC = 4,
    localparam int CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_en,
    output logic [CH_NUM-1:0] div_clk,
    output logic [CH_NUM-1:0] clk_en,
    output logic [CH_NUM-1:0] ch_reset_n,
    output logic [CH_NUM-1:0] ch_run
);
    logic [CH_NUM-1:0]      pending;
    logic [(1<<CH_W)-1:0]   pend_ext;

    // Unpopulated channel codes read as ready and are silently dropped.
    always_comb begin
        pend_ext = '0;
        for (int i = 0; i < CH_NUM; i++) pend_ext[i] = pending[i];
    end
    assign cfg_ready = !pend_ext[cfg_ch];

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        jvs_clk_div_ch #(.DIV_W(DIV_W), .RST_CYC(RST_CYC)) u_ch (
            .clk_i        (clock),
            .rst_ni       (reset_n),
            .wr_i         (cfg_valid && cfg_ready && (cfg_ch == CH_W'(i))),
            .div_i        (cfg_div),
            .en_i         (cfg_en),
            .pending_o    (pending[i]),
            .div_clk_o    (div_clk[i]),
            .clk_en_o     (clk_en[i]),
            .ch_reset_n_o (ch_reset_n[i]),
            .ch_run_o     (ch_run[i])
        );
    end
endmodule

// File: tb/tb_jvs_clk_div_group.sv
// Directed bench for jvs_clk_div_group: enable/reset sequencing, glitch-free
// divider change, disable, stall, async reset, and D=0 with RST_CYC=1.

module tb_jvs_clk_div_group;
    logic       clock, reset_n;
    int         cyc = 0;
    int         n_chk = 0, n_err = 0;

    // DUT a: 4 channels, RST_CYC=4
    logic       a_valid, a_ready, a_en;
    logic [1:0] a_ch;
    logic [7:0] a_div;
    logic [3:0] a_dclk, a_ce, a_rstn, a_run;
    // DUT b: 2 channels, RST_CYC=1
    logic       b_valid, b_ready, b_en;
    logic [0:0] b_ch;
    logic [7:0] b_div;
    logic [1:0] b_dclk, b_ce, b_rstn, b_run;

    jvs_clk_div_group #(.CH_NUM(4), .DIV_W(8), .RST_CYC(4)) u_dut_a (
        .clock(clock), .reset_n(reset_n), .cfg_valid(a_valid), .cfg_ready(a_ready),
        .cfg_ch(a_ch), .cfg_div(a_div), .cfg_en(a_en), .div_clk(a_dclk),
        .clk_en(a_ce), .ch_reset_n(a_rstn), .ch_run(a_run));

    jvs_clk_div_group #(.CH_NUM(2), .DIV_W(8), .RST_CYC(1)) u_dut_b (
        .clock(clock), .reset_n(reset_n), .cfg_valid(b_valid), .cfg_ready(b_ready),
        .cfg_ch(b_ch), .cfg_div(b_div), .cfg_en(b_en), .div_clk(b_dclk),
        .clk_en(b_ce), .ch_reset_n(b_rstn), .ch_run(b_run));

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic at_cyc(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    // Expected {div_clk, clk_en, ch_reset_n, ch_run} rel cycles after enable accept.
    function automatic logic [3:0] model(input int rel, input int dv, input int rc);
        int  first, per, rel_rst;
        logic dh, ce, rs;
        first   = dv + 2;
        per     = 2 * (dv + 1);
        rel_rst = first + (rc - 1) * per + dv + 1;
        dh = (rel >= first) && (((rel - first) % per) < dv + 1);
        ce = (rel >= first) && (((rel - first) % per) == 0);
        rs = (rel >= rel_rst);
        return {dh, ce, rs, rs};
    endfunction

    function automatic logic [3:0] obs(input bit which, input int ch);
        if (which) return {b_dclk[ch], b_ce[ch], b_rstn[ch], b_run[ch]};
        return {a_dclk[ch], a_ce[ch], a_rstn[ch], a_run[ch]};
    endfunction

    // Called at a negedge; returns at the negedge of the accept cycle.
    task automatic send(input bit which, input int ch, input int dv, input bit en,
                        output int acc, output int stalls);
        int t = 0;
        if (which) begin b_valid = 1'b1; b_ch = 1'(ch); b_div = 8'(dv); b_en = en; end
        else begin a_valid = 1'b1; a_ch = 2'(ch); a_div = 8'(dv); a_en = en; end
        #1;
        while (!(which ? b_ready : a_ready) && t < 50) begin
            @(negedge clock); #1; t++;
        end
        if (t >= 50) check("cfg_stall_timeout", 32'(t), 32'd0);
        @(posedge clock);
        @(negedge clock);
        acc    = cyc;
        stalls = t;
        if (which) b_valid = 1'b0; else a_valid = 1'b0;
    endtask

    task automatic sweep(input bit which, input int ch, input int acc, input int dv,
                         input int rc, input int from, input int to);
        for (int c = from; c <= to; c++) begin
            at_cyc(c);
            check($sformatf("seq_d%0d_ch%0d_c%0d", which, ch, c),
                  32'(obs(which, ch)), 32'(model(c - acc, dv, rc)));
        end
    endtask

    initial begin
        int a, b, p, c, e, f, g, h, r, s, st;
        reset_n = 1'b0;
        a_valid = 1'b0; a_ch = '0; a_div = '0; a_en = 1'b0;
        b_valid = 1'b0; b_ch = '0; b_div = '0; b_en = 1'b0;

        // Reset state
        at_cyc(3);
        check("rst_div_clk", 32'(a_dclk), 32'd0);
        check("rst_clk_en", 32'(a_ce), 32'd0);
        check("rst_ch_reset_n", 32'(a_rstn), 32'd0);
        check("rst_ch_run", 32'(a_run), 32'd0);
        check("rst_cfg_ready", 32'(a_ready), 32'd1);
        reset_n = 1'b1;

        // Enable ch0 D=1 accepted at cycle 10
        at_cyc(9);
        send(0, 0, 1, 1'b1, a, st);
        check("s1_accept_cycle", 32'(a), 32'd10);
        sweep(0, 0, a, 1, 4, a, a + 22);

        // ch1 D=3, then D=0 requested in the second cycle of a low phase
        at_cyc(a + 29);
        send(0, 1, 3, 1'b1, b, st);
        sweep(0, 1, b, 3, 4, b, b + 41);
        send(0, 1, 0, 1'b1, p, st);
        check("s2_accept_cycle", 32'(p), 32'(b + 42));
        for (int k = p; k <= p + 12; k++) begin
            at_cyc(k);
            a_ch = 2'd1; #1;
            check($sformatf("s2_ready_ch1_c%0d", k), 32'(a_ready), 32'(k >= b + 45));
            a_ch = 2'd2; #1;
            check($sformatf("s2_ready_ch2_c%0d", k), 32'(a_ready), 32'd1);
            check($sformatf("s2_ch1_c%0d", k), 32'({a_dclk[1], a_ce[1], a_rstn[1]}),
                  (k <= b + 44) ? 32'd1 : ((((k - b - 45) % 2) == 0) ? 32'd7 : 32'd1));
        end

        // ch2 D=7 running, disabled in cycle 2 of a high phase
        at_cyc(b + 60);
        send(0, 2, 7, 1'b1, c, st);
        sweep(0, 2, c, 7, 4, c, c + 73);
        send(0, 2, 7, 1'b0, f, st);
        check("s3_accept_cycle", 32'(f), 32'(c + 74));
        for (int k = c + 74; k <= c + 100; k++) begin
            at_cyc(k);
            check($sformatf("s3_ch2_c%0d", k), 32'(obs(0, 2)),
                  32'({(k <= c + 80), 1'b0, (k <= c + 74), (k <= c + 74)}));
        end

        // ch3 D=1, disable, immediate re-enable D=2 stalls behind it
        at_cyc(c + 102);
        send(0, 3, 1, 1'b1, e, st);
        sweep(0, 3, e, 1, 4, e, e + 20);
        send(0, 3, 1, 1'b0, f, st);
        send(0, 3, 2, 1'b1, g, st);
        check("s4_stall_count", 32'(st), 32'd1);
        check("s4_reaccept_cycle", 32'(g), 32'(f + 2));
        sweep(0, 3, g, 2, 4, g, g + 30);

        // All four running, ch2 change pending, then a one-cycle reset pulse
        at_cyc(g + 32);
        send(0, 2, 7, 1'b1, h, st);
        at_cyc(h + 65);
        send(0, 2, 3, 1'b1, p, st);
        a_ch = 2'd2; #1;
        check("s5_pending_ready", 32'(a_ready), 32'd0);
        check("s5_all_run", 32'(a_run), 32'hf);
        reset_n = 1'b0; #1;
        check("s5_rst_div_clk", 32'(a_dclk), 32'd0);
        check("s5_rst_clk_en", 32'(a_ce), 32'd0);
        check("s5_rst_ch_reset_n", 32'(a_rstn), 32'd0);
        check("s5_rst_ch_run", 32'(a_run), 32'd0);
        check("s5_rst_cfg_ready", 32'(a_ready), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        at_cyc(h + 69);
        send(0, 0, 1, 1'b1, r, st);
        sweep(0, 0, r, 1, 4, r, r + 30);
        check("s5_others_idle_div", 32'(a_dclk[3:1]), 32'd0);
        check("s5_others_idle_run", 32'(a_run[3:1]), 32'd0);

        // D=0 with RST_CYC=1 on the second instance
        at_cyc(r + 32);
        send(1, 1, 0, 1'b1, s, st);
        sweep(1, 1, s, 0, 1, s, s + 12);
        check("s6_ch0_idle", 32'(b_dclk[0]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/jvs_clk_div_group.md
# jvs_clk_div_group

Synthesisable, parametrised clock-generation group: from one root clock it produces `CH_NUM` independently programmable divided clocks. Each channel has its own clock-enable pulse and its own sequenced active-low reset. It is the RTL successor of the testbench-only generated-clock group. Software or a sequencer programs each channel through a valid/ready config port. Divider changes take effect glitch-free, and enable/disable walk each channel through a reset sequence.

## Interface

**Parameters**
- `CH_NUM`, 4: number of generated channels (1..16).
- `DIV_W`, 8: width of divider value D.
- `RST_CYC`, 4: number of divided-clock rising edges for which `ch_reset_n` is held low after enable (1..255).

**Ports**
- `clock` in 1: root clock; all logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cfg_valid` in 1: config request.
- `cfg_ready` out 1: config accept; equals `!pending[cfg_ch]`.
- `cfg_ch` in $clog2(CH_NUM): target channel.
- `cfg_div` in DIV_W: divider value D.
- `cfg_en` in 1: channel enable.
- `div_clk` out CH_NUM: divided clocks, registered.
- `clk_en` out CH_NUM: one-cycle pulse in the first cycle of each `div_clk` high phase.
- `ch_reset_n` out CH_NUM: per-channel sequenced reset.
- `ch_run` out CH_NUM: 1 while the channel is in RUN.

## Operation

**Per-channel state**
- States: OFF, RST, RUN, STOP.
- Registers: counter `cnt` (DIV_W), active divider `d`, rise counter `rcnt` (8 bit), one-entry shadow {div, en} plus a `pending` flag.

**Divider**
- In RST, RUN and STOP, `cnt` increments each cycle.
- When `cnt==d`: `cnt` goes to 0 and `div_clk` toggles.
- Each phase lasts d+1 cycles, so the period is 2(d+1). With D=0 the output toggles every cycle.
- A rising `div_clk` sets `clk_en` for that same first high cycle.

**Config handshake**
- A transfer occurs when `cfg_valid && cfg_ready`.
- On transfer, the shadow is written and `pending` is set.
- While `pending` is set, further requests to that channel stall (`cfg_ready=0`). Requests to other channels are unaffected.

**Applying pending config**
- OFF with en=1: the next cycle loads `d`, clears `cnt`/`rcnt`, keeps `div_clk=0`, and enters RST. `pending` clears.
- OFF with en=0: `pending` clears with no other effect.
- RST/RUN with en=1: the new D loads on the cycle `div_clk` rises (`cnt==d && div_clk==0`). The high phase and all later phases use the new D, so there are no runt phases. `pending` clears.
- RST/RUN with en=0: the next cycle drives `ch_reset_n` to 0, clears `pending`, and enters STOP.
- STOP: a pending en=1 is held until OFF is reached, then applied as for OFF.

**RST**
- `ch_reset_n` stays 0.
- `rcnt` increments on each `div_clk` rise.
- On the `div_clk` fall following rise number `RST_CYC`, set `ch_reset_n=1` and enter RUN.

**STOP**
- If `div_clk` is high, the high phase completes, `div_clk` falls, and the channel enters OFF.
- If `div_clk` is low, enter OFF the next cycle with `div_clk` parked at 0.

**OFF**
- `div_clk=0`, `cnt=0`, `ch_reset_n=0`, `clk_en=0`.

## Timing

- Reset values (asynchronous): all channels OFF; `div_clk=0`, `clk_en=0`, `ch_reset_n=0`, `ch_run=0`, `pending=0`, so `cfg_ready=1`.
- Assertion of `reset_n` mid-operation forces these values immediately, with no phase completion.
- Enable latency: accept at cycle a; RST from a+1; first `div_clk` rise at a+1+(D+1).
- With D=1 and RST_CYC=4: rises at a+3, a+7, a+11, a+15; `ch_reset_n=1` and `ch_run=1` from a+17.
- Disable latency: `ch_reset_n=0` and `ch_run=0` in the cycle after accept. `div_clk` is low no later than d+1 cycles after accept.
- `cfg_ready` is combinational from `pending[cfg_ch]`. It never depends on `cfg_valid`.
- A change of D is visible from the next `div_clk` rise. Worst-case wait is 2(d_old+1) cycles.
- All channels are independent. Simultaneous events on different channels do not interact.
- `clk_en` is high for exactly one root cycle per `div_clk` period, including D=0.

## Test plan

- Reset then enable ch0 with D=1, RST_CYC=4 accepted at cycle 10 -> `div_clk[0]` rises at 13, 17, 21, 25. `ch_reset_n[0]` and `ch_run[0]` go to 1 at 27. `clk_en[0]` pulses at 13, 17, 21, 25, 29.
- Ch1 running at D=3, reprogrammed to D=0 mid-low-phase -> the current low phase stays 4 cycles, then the period is 2 with no phase shorter than 1 cycle. `cfg_ready` for ch1 is low from accept until the rise, and `cfg_ready` for ch2 stays 1 throughout.
- Ch2 running at D=7, disabled at cycle 2 of a high phase -> `ch_reset_n[2]=0` next cycle. The high phase still lasts 8 cycles, then `div_clk[2]` stays 0.
- Ch3 disabled then re-enabled (D=2) on the cycle after -> the second request stalls while the first is pending. The channel then goes STOP -> OFF -> RST and the full 4-rise reset sequence repeats.
- `reset_n` pulsed low for 1 cycle while all 4 channels are running -> all outputs are 0 in the same cycle and `cfg_ready=1`. A subsequent enable behaves as in scenario 1.
- D=0 with RST_CYC=1 -> `div_clk` toggles every cycle, and `ch_reset_n` goes to 1 at accept+3.
